ram_mem_param: RTL and testbench

Parametrised single-port simulation/FPGA RAM, successor of the fixed 16-bit RAM model. It adds:
- configurable word width and depth;
- byte-enable writes;
- a valid/ready request port with a configurable read latency;
- a reset-time scrub state machine that zero-fills the array.

Every read returns two consecutive words, `addr` and `addr+1` with wrap-around, so the core fetch path can assemble misaligned and compressed instructions. It sits between the RS5 core memory interface and the testbench/FPGA memory map.

---
 rtl/ram_mem_param_pkg.sv | 11 +
 rtl/ram_mem_param_rd_pipe.sv | 45 ++++
 rtl/ram_mem_param.sv | 129 ++++++++++++
 tb/tb_ram_mem_param.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_mem_param_pkg.sv
// rtl/ram_mem_param_pkg.sv - shared types and limits for the parametrised RAM
package ram_mem_param_pkg;

  typedef enum logic [0:0] {
    RAM_SCRUB = 1'b0,
    RAM_READY = 1'b1
  } ram_state_e;

  localparam int RAM_MAX_READ_LATENCY = 4;

endpackage

// File: rtl/ram_mem_param_rd_pipe.sv
// rtl/ram_mem_param_rd_pipe.sv - read response delay line carrying {valid, word_a, word_b}
// Only the valid bits are flushed; data stages are qualified by valid downstream.
module ram_rd_pipe #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b
);

  logic [LATENCY-1:0] vld_q;
  logic [WIDTH-1:0]   a_q [LATENCY];
  logic [WIDTH-1:0]   b_q [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    a_q[0] <= in_a;
    b_q[0] <= in_b;
    for (int i = 1; i < LATENCY; i++) begin
      a_q[i] <= a_q[i-1];
      b_q[i] <= b_q[i-1];
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_a     = a_q[LATENCY-1];
  assign out_b     = b_q[LATENCY-1];

endmodule

// File: rtl/ram_mem_param.sv
// rtl/ram_mem_param.sv - single-port RAM with byte enables, dual-word reads and reset scrub
// Every read returns mem[addr] and mem[addr+1] so misaligned fetches need one access.
module ram_mem_param
  import ram_mem_param_pkg::*;
#(
  parameter int DEPTH        = 65536,
  parameter int WORD_WIDTH   = 16,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    we_i,
  input  logic [WORD_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [WORD_WIDTH-1:0]   data_i,
  output logic                    rsp_valid_o,
  output logic [WORD_WIDTH-1:0]   data_o_a,
  output logic [WORD_WIDTH-1:0]   data_o_b,
  output logic                    busy_o
);

  localparam int BE_WIDTH = WORD_WIDTH / 8;
  localparam logic [0:0] ST_SCRUB = RAM_SCRUB;
  localparam logic [0:0] ST_READY = RAM_READY;

  if (READ_LATENCY < 1 || READ_LATENCY > RAM_MAX_READ_LATENCY) begin : g_bad_latency
    $error("ram_mem_param: READ_LATENCY out of range");
  end
  if (WORD_WIDTH % 8 != 0 || WORD_WIDTH == 0) begin : g_bad_width
    $error("ram_mem_param: WORD_WIDTH must be a non-zero multiple of 8");
  end

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] scrub_cnt;
  logic                  scrub_done;
  logic                  ready_q;
  logic                  busy_q;
  logic                  rd_accept;
  logic                  wr_accept;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  pipe_valid;
  logic [WORD_WIDTH-1:0] pipe_a;
  logic [WORD_WIDTH-1:0] pipe_b;
  logic                  rsp_valid_q;
  logic [WORD_WIDTH-1:0] data_a_q;
  logic [WORD_WIDTH-1:0] data_b_q;

  assign rd_accept = req_valid_i && ready_q && !we_i;
  assign wr_accept = req_valid_i && ready_q && we_i;
  assign addr_nxt  = addr_i + ADDR_WIDTH'(1);

  // scrub_done marks the final zero write; the state flips one edge later so
  // busy covers cycles 1..DEPTH and the registered ready rises on DEPTH+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SCRUB;
      scrub_cnt  <= '0;
      scrub_done <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      busy_q  <= (state == ST_SCRUB) && ((scrub_cnt != '0) || scrub_done);
      ready_q <= (state == ST_READY);
      if (state == ST_SCRUB) begin
        if (!scrub_done) begin
          scrub_cnt <= scrub_cnt + ADDR_WIDTH'(1);
          if (scrub_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            scrub_done <= 1'b1;
          end
        end else begin
          state <= ST_READY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_SCRUB && !scrub_done) begin
      mem[scrub_cnt] <= '0;
    end else if (wr_accept) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (be_i[i]) begin
          mem[addr_i][8*i +: 8] <= data_i[8*i +: 8];
        end
      end
    end
  end

  ram_rd_pipe #(
    .LATENCY (READ_LATENCY),
    .WIDTH   (WORD_WIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_accept),
    .in_a      (mem[addr_i]),
    .in_b      (mem[addr_nxt]),
    .out_valid (pipe_valid),
    .out_a     (pipe_a),
    .out_b     (pipe_b)
  );

  // The output stage is the last latency cycle and also holds data between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      data_a_q    <= '0;
      data_b_q    <= '0;
    end else begin
      rsp_valid_q <= pipe_valid;
      if (pipe_valid) begin
        data_a_q <= pipe_a;
        data_b_q <= pipe_b;
      end
    end
  end

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign data_o_a    = data_a_q;
  assign data_o_b    = data_b_q;

endmodule

// File: tb/tb_ram_mem_param.sv
// tb/tb_ram_mem_param.sv - scoreboard bench driving four RAM instances (latency 1..4) in lockstep
module tb_ram_mem_param;

  localparam int DEPTH = 16;
  localparam int WW    = 16;
  localparam int NI    = 4;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [3:0]  addr = 4'd0;
  logic [15:0] wdata = 16'h0000;

  logic        ready     [NI];
  logic        rsp_valid [NI];
  logic        busy      [NI];
  logic [15:0] da        [NI];
  logic [15:0] db        [NI];

  exp_t        sb [NI][$];
  logic [15:0] ref_mem [DEPTH];

  int edge_n   = 0;
  int checks   = 0;
  int errors   = 0;
  int spurious = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ram_mem_param #(
      .DEPTH        (DEPTH),
      .WORD_WIDTH   (WW),
      .READ_LATENCY (g + 1)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_ready_o (ready[g]),
      .we_i        (we),
      .be_i        (be),
      .addr_i      (addr),
      .data_i      (wdata),
      .rsp_valid_o (rsp_valid[g]),
      .data_o_a    (da[g]),
      .data_o_b    (db[g]),
      .busy_o      (busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rsp_valid[g]) begin
        if (sb[g].size() == 0) begin
          spurious++;
          check($sformatf("L%0d unexpected rsp_valid", g + 1), 32'(rsp_valid[g]), 32'd0);
        end else begin
          exp_t e;
          e = sb[g].pop_front();
          check($sformatf("L%0d rsp cycle", g + 1), 32'(edge_n), 32'(e.due));
          check($sformatf("L%0d data_o_a", g + 1), 32'(da[g]), 32'(e.a));
          check($sformatf("L%0d data_o_b", g + 1), 32'(db[g]), 32'(e.b));
        end
      end else if (sb[g].size() > 0 && sb[g][0].due <= edge_n) begin
        check($sformatf("L%0d missing rsp_valid", g + 1), 32'(rsp_valid[g]), 32'd1);
        void'(sb[g].pop_front());
      end
    end
  end

  task automatic req(input logic w, input logic [1:0] b, input logic [3:0] a, input logic [15:0] d);
    logic [3:0] an;
    exp_t       e;
    an = a + 4'd1;
    req_valid = 1'b1;
    we = w;
    be = b;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    if (!w) begin
      for (int g = 0; g < NI; g++) begin
        e.a = ref_mem[a];
        e.b = ref_mem[an];
        e.due = edge_n + g + 1;
        sb[g].push_back(e);
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (b[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  task automatic drain();
    req_valid = 1'b0;
    we = 1'b0;
    repeat (7) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("L%0d scoreboard drained", g + 1), 32'(sb[g].size()), 32'd0);
    end
  endtask

  initial begin
    int spur0;
    int waited;
    logic saw_busy;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("L%0d reset req_ready_o", g + 1), 32'(ready[g]), 32'd0);
      check($sformatf("L%0d reset rsp_valid_o", g + 1), 32'(rsp_valid[g]), 32'd0);
      check($sformatf("L%0d reset data_o_a", g + 1), 32'(da[g]), 32'd0);
      check($sformatf("L%0d reset data_o_b", g + 1), 32'(db[g]), 32'd0);
      check($sformatf("L%0d reset busy_o", g + 1), 32'(busy[g]), 32'd0);
    end

    // Release reset with a write held on the port; it must be ignored until ready.
    rst = 1'b0;
    req_valid = 1'b1; we = 1'b1; be = 2'b11; addr = 4'd15; wdata = 16'hFFFF;
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        check($sformatf("L%0d busy_o cycle %0d", g + 1, k), 32'(busy[g]), 32'((k >= 1 && k <= 16) ? 1 : 0));
        check($sformatf("L%0d req_ready_o cycle %0d", g + 1, k), 32'(ready[g]), 32'((k >= 17) ? 1 : 0));
      end
      if (k == 16) req_valid = 1'b0;
    end

    req(1'b0, 2'b00, 4'd5, 16'h0);
    req(1'b0, 2'b00, 4'd15, 16'h0);
    drain();

    req(1'b1, 2'b11, 4'd3, 16'hBEEF);
    req(1'b1, 2'b10, 4'd3, 16'h12AB);
    req(1'b0, 2'b00, 4'd3, 16'h0);
    req(1'b0, 2'b00, 4'd2, 16'h0);
    drain();
    check("model byte-enable merge", 32'(ref_mem[3]), 32'h12EF);

    req(1'b1, 2'b11, 4'd15, 16'hAAAA);
    req(1'b1, 2'b11, 4'd0, 16'h5555);
    req(1'b0, 2'b00, 4'd15, 16'h0);
    drain();

    for (int i = 0; i < 8; i++) begin
      req(1'b1, 2'($urandom_range(1, 3)), 4'(i * 5 + 1), 16'($urandom_range(0, 65535)));
    end
    for (int i = 0; i < 8; i++) begin
      req(1'b0, 2'b00, 4'(i * 3 + 4), 16'h0);
    end
    drain();

    req(1'b1, 2'b11, 4'd7, 16'h1234);
    req(1'b0, 2'b00, 4'd6, 16'h0);
    drain();

    // Read accepted, then reset on the following edge: the response must vanish.
    req(1'b0, 2'b00, 4'd7, 16'h0);
    rst = 1'b1;
    req_valid = 1'b0;
    for (int g = 0; g < NI; g++) sb[g].delete();
    spur0 = spurious;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
    waited = 0;
    saw_busy = 1'b0;
    while (!ready[0] && waited < 40) begin
      @(negedge clk);
      if (busy[0]) saw_busy = 1'b1;
      waited++;
    end
    check("ready after mid-flight reset", 32'(ready[0]), 32'd1);
    check("scrub restarted after reset", 32'(saw_busy), 32'd1);
    check("no response across reset", 32'(spurious - spur0), 32'd0);
    req(1'b0, 2'b00, 4'd7, 16'h0);
    req(1'b0, 2'b00, 4'd2, 16'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
